// File: rtl/f2c_dma_sched.sv
// f2c_dma_sched: FPGA->CPU DMA command scheduler.
// Cuts the source TLP stream into chunks of 2^CHUNK_TLPS_LOG2 data TLPs, writes
// them into a host ring of 2^NUM_CHUNKS_LOG2 chunks, and publishes the new
// write pointer with a single-DW metrics write after each complete chunk.
// Optional feature: define F2C_STALL_COUNT_EN to build the ring-full stall counter.
module f2c_dma_sched #(
  parameter int NUM_CHUNKS_LOG2 = 2,
  parameter int CHUNK_TLPS_LOG2 = 2,
  parameter int TLP_QWS         = 16
) (
  input  logic                       pcieClk_in,
  input  logic                       pcieRst_in,
  input  logic                       dmaEnable_in,
  input  logic [31:0]                f2cBase_in,
  input  logic [31:0]                mtrBase_in,
  input  logic [NUM_CHUNKS_LOG2-1:0] rdPtr_in,
  input  logic                       srcTlpReady_in,
  output logic                       srcTlpPop_out,
  output logic                       cmdValid_out,
  input  logic                       cmdReady_in,
  output logic                       cmdIsMtr_out,
  output logic [31:0]                cmdAddr_out,
  output logic [31:0]                cmdData_out,
  output logic [NUM_CHUNKS_LOG2-1:0] wrPtr_out,
  output logic                       busy_out,
  output logic [31:0]                stallCount_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_MTR  = 2'd2;

  logic [1:0]                 state;
  logic [NUM_CHUNKS_LOG2-1:0] wr_ptr;
  logic [NUM_CHUNKS_LOG2-1:0] wr_ptr_inc;
  logic [CHUNK_TLPS_LOG2-1:0] tlp_idx;
  logic                       cmd_valid;
  logic                       cmd_is_mtr;
  logic [31:0]                cmd_addr;
  logic [31:0]                cmd_data;
  logic                       ring_full;
  logic                       start_ok;
  logic [31:0]                data_addr;

  // The ring is full when advancing the write pointer would land on the host read pointer.
  assign wr_ptr_inc = wr_ptr + 1'b1;
  assign ring_full  = (wr_ptr_inc == rdPtr_in);

  // Full is only a blocker at a chunk boundary; a chunk already begun always completes.
  assign start_ok = dmaEnable_in && srcTlpReady_in && ((tlp_idx != '0) || !ring_full);

  // Ring slot address: TLP number within the ring times TLP size, 32-bit wrap.
  assign data_addr = f2cBase_in + (32'({wr_ptr, tlp_idx}) * 32'(TLP_QWS));

  // Main sequencer: command issue, chunk/ring bookkeeping and registered command outputs.
  always_ff @(posedge pcieClk_in) begin
    // NOTE: every register here is assigned with <= so all of them update from the
    // same pre-edge values; mixing in = would make results depend on statement order.
    if (pcieRst_in) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      tlp_idx    <= '0;
      cmd_valid  <= 1'b0;
      cmd_is_mtr <= 1'b0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!dmaEnable_in) begin
            wr_ptr  <= '0;
            tlp_idx <= '0;
          end else if (start_ok) begin
            state      <= ST_DATA;
            cmd_valid  <= 1'b1;
            cmd_is_mtr <= 1'b0;
            cmd_addr   <= data_addr;
            cmd_data   <= '0;
          end
        end
        ST_DATA: begin
          // The command stays up until taken, even if DMA is disabled meanwhile.
          if (cmdReady_in) begin
            cmd_valid <= 1'b0;
            tlp_idx   <= tlp_idx + 1'b1;
            if (&tlp_idx) begin
              wr_ptr <= wr_ptr_inc;
              state  <= ST_MTR;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_MTR: begin
          // First MTR cycle is the mandatory gap; the metrics write is raised after it.
          if (!cmd_valid) begin
            cmd_valid  <= 1'b1;
            cmd_is_mtr <= 1'b1;
            cmd_addr   <= mtrBase_in;
            cmd_data   <= 32'(wr_ptr);
          end else if (cmdReady_in) begin
            cmd_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef F2C_STALL_COUNT_EN
  logic [31:0] stall_cnt;

  // Saturating count of chunk-start cycles lost to a full ring; cleared while disabled.
  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in || !dmaEnable_in) begin
      stall_cnt <= '0;
    end else if ((state == ST_IDLE) && srcTlpReady_in && (tlp_idx == '0) && ring_full
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stallCount_out = stall_cnt;
`else
  assign stallCount_out = '0;
`endif

  // NOTE: the pop is combinational on the accept so it lands in the accept cycle;
  // it is gated by reset so a reset edge wins over a handshake in the same cycle.
  assign srcTlpPop_out = (state == ST_DATA) && cmdReady_in && !pcieRst_in;
  assign cmdValid_out  = cmd_valid;
  assign cmdIsMtr_out  = cmd_is_mtr;
  assign cmdAddr_out   = cmd_addr;
  assign cmdData_out   = cmd_data;
  assign wrPtr_out     = wr_ptr;
  assign busy_out      = (state != ST_IDLE);

endmodule

// File: tb/tb_f2c_dma_sched.sv
// tb_f2c_dma_sched: directed scenarios plus randomized traffic for f2c_dma_sched,
// checked every cycle against a transaction-level ring/chunk model.
module tb_f2c_dma_sched;

  localparam int NCL = 2;
  localparam int CTL = 2;
  localparam int TQ  = 16;
  localparam int NCH = 1 << NCL;
  localparam int NT  = 1 << CTL;
`ifdef F2C_STALL_COUNT_EN
  localparam int STALL_ON = 1;
`else
  localparam int STALL_ON = 0;
`endif

  typedef struct {
    int          cyc;
    bit          mtr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           dma_en = 1'b0;
  logic [31:0]    f2c_base = '0;
  logic [31:0]    mtr_base = '0;
  logic [NCL-1:0] rd_ptr = '0;
  logic           src_ready = 1'b0;
  logic           cmd_ready = 1'b0;

  logic           src_pop;
  logic           cmd_valid;
  logic           cmd_is_mtr;
  logic [31:0]    cmd_addr;
  logic [31:0]    cmd_data;
  logic [NCL-1:0] wr_ptr;
  logic           busy;
  logic [31:0]    stall_count;

  f2c_dma_sched #(
    .NUM_CHUNKS_LOG2(NCL),
    .CHUNK_TLPS_LOG2(CTL),
    .TLP_QWS        (TQ)
  ) dut (
    .pcieClk_in    (clk),
    .pcieRst_in    (rst),
    .dmaEnable_in  (dma_en),
    .f2cBase_in    (f2c_base),
    .mtrBase_in    (mtr_base),
    .rdPtr_in      (rd_ptr),
    .srcTlpReady_in(src_ready),
    .srcTlpPop_out (src_pop),
    .cmdValid_out  (cmd_valid),
    .cmdReady_in   (cmd_ready),
    .cmdIsMtr_out  (cmd_is_mtr),
    .cmdAddr_out   (cmd_addr),
    .cmdData_out   (cmd_data),
    .wrPtr_out     (wr_ptr),
    .busy_out      (busy),
    .stallCount_out(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: ring write pointer, TLP index in chunk, owed metrics write.
  int          m_wp = 0;
  int          m_idx = 0;
  bit          m_expect_mtr = 0;
  logic [31:0] m_stall = '0;
  bit          exp_valid = 0;
  bit          hold = 0;
  bit          h_mtr;
  logic [31:0] h_addr;
  logic [31:0] h_data;
  int          cycle = 0;
  int          pops = 0;
  acc_t        accq[$];

  function automatic bit ring_full(input int wp, input logic [NCL-1:0] rp);
    return ((wp + 1) % NCH) == int'(rp);
  endfunction

  // Compare outputs after the last edge, then advance the model across the next edge.
  task automatic observe();
    bit accept;
    bit idle;
    if (rst) begin
      check("pop_in_reset", src_pop, 1'b0);
      m_wp = 0; m_idx = 0; m_expect_mtr = 0; m_stall = '0; exp_valid = 0; hold = 0;
      cycle++;
      return;
    end
    check("valid", cmd_valid, exp_valid);
    check("wr_ptr", wr_ptr, m_wp);
    check("stall_count", stall_count, m_stall);
    check("busy", busy, cmd_valid || m_expect_mtr);
    if (hold) begin
      check("hold_mtr", cmd_is_mtr, h_mtr);
      check("hold_addr", cmd_addr, h_addr);
      check("hold_data", cmd_data, h_data);
    end
    if (cmd_valid) check("is_mtr", cmd_is_mtr, m_expect_mtr);
    accept = cmd_valid && cmd_ready;
    check("pop", src_pop, accept && !m_expect_mtr);
    if (src_pop) pops++;
    idle = !cmd_valid && !m_expect_mtr;
    if (STALL_ON != 0) begin
      if (!dma_en) m_stall = '0;
      else if (idle && src_ready && m_idx == 0 && ring_full(m_wp, rd_ptr) && m_stall != '1)
        m_stall = m_stall + 32'd1;
    end
    hold = 0;
    if (idle) begin
      if (!dma_en) begin
        m_wp = 0; m_idx = 0; exp_valid = 0;
      end else begin
        exp_valid = src_ready && (m_idx != 0 || !ring_full(m_wp, rd_ptr));
      end
    end else if (!cmd_valid) begin
      exp_valid = 1;
    end else if (!accept) begin
      exp_valid = 1; hold = 1; h_mtr = cmd_is_mtr; h_addr = cmd_addr; h_data = cmd_data;
    end else begin
      exp_valid = 0;
      accq.push_back('{cycle, m_expect_mtr, cmd_addr, cmd_data});
      if (m_expect_mtr) begin
        check("mtr_addr", cmd_addr, mtr_base);
        check("mtr_data", cmd_data, 32'(m_wp));
        m_expect_mtr = 0;
      end else begin
        check("data_addr", cmd_addr, f2c_base + 32'((m_wp * NT + m_idx) * TQ));
        check("data_data", cmd_data, 32'd0);
        m_idx++;
        if (m_idx == NT) begin
          m_idx = 0; m_wp = (m_wp + 1) % NCH; m_expect_mtr = 1;
        end
      end
    end
    cycle++;
  endtask

  task automatic step();
    #1;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, cmd_valid, 1'b0);
    check({tag, "_is_mtr"}, cmd_is_mtr, 1'b0);
    check({tag, "_addr"}, cmd_addr, 32'd0);
    check({tag, "_data"}, cmd_data, 32'd0);
    check({tag, "_pop"}, src_pop, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_wr_ptr"}, wr_ptr, '0);
    check({tag, "_stall"}, stall_count, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0, p0, n;

    // Reset with busy-looking inputs.
    rst = 1; dma_en = 1; src_ready = 1; cmd_ready = 1;
    repeat (3) step();
    check_reset_outputs("reset");

    // Three chunks fill the ring with rdPtr held at 0.
    dma_en = 0; rst = 0;
    step();
    f2c_base = 32'h100; mtr_base = 32'h800; rd_ptr = 0;
    dma_en = 1; src_ready = 1; cmd_ready = 1;
    accq.delete(); pops = 0;
    repeat (40) step();
    check("fill_count", accq.size(), 15);
    if (accq.size() == 15) begin
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i < NT; i++) begin
          check("fill_data_addr", accq[c*5+i].addr, 32'h100 + 32'((c * NT + i) * TQ));
          check("fill_data_kind", accq[c*5+i].mtr, 1'b0);
          check("fill_data_spacing", accq[c*5+i].cyc - accq[c*5].cyc, 2 * i);
        end
        check("fill_mtr_kind", accq[c*5+4].mtr, 1'b1);
        check("fill_mtr_addr", accq[c*5+4].addr, 32'h800);
        check("fill_mtr_data", accq[c*5+4].data, c + 1);
        check("fill_mtr_spacing", accq[c*5+4].cyc - accq[c*5].cyc, 8);
      end
      check("chunk_period", accq[5].cyc - accq[0].cyc, 10);
    end
    check("fill_pops", pops, 12);
    check("full_wr_ptr", wr_ptr, 3);
    check("full_busy", busy, 1'b0);

    // Host frees a slot: the fourth chunk goes to slot 3 and wraps the pointer.
    rd_ptr = 1;
    repeat (12) step();
    check("wrap_count", accq.size(), 20);
    if (accq.size() == 20) begin
      check("wrap_first_addr", accq[15].addr, 32'h1C0);
      check("wrap_mtr_kind", accq[19].mtr, 1'b1);
      check("wrap_mtr_data", accq[19].data, 32'd0);
    end

    // Stall counter: ring full for exactly 20 idle cycles, then disable.
    dma_en = 0; rd_ptr = 1;
    repeat (2) step();
    check("stall_cleared", stall_count, 32'd0);
    check("disable_wr_ptr", wr_ptr, '0);
    n0 = accq.size();
    dma_en = 1;
    repeat (20) step();
    check("stall_20", stall_count, (STALL_ON != 0) ? 32'd20 : 32'd0);
    check("stall_no_cmd", accq.size(), n0);
    dma_en = 0;
    step();
    check("stall_after_disable", stall_count, 32'd0);

    // Backpressure mid chunk 1 on TLP 2.
    rd_ptr = 0; dma_en = 1; cmd_ready = 1;
    n = 0;
    while (n < 60 && !(m_wp == 1 && m_idx == 2 && !m_expect_mtr)) begin step(); n++; end
    check("reach_chunk1_tlp2", (m_wp == 1 && m_idx == 2), 1'b1);
    cmd_ready = 0;
    n = 0;
    while (n < 5 && !cmd_valid) begin step(); n++; end
    check("bp_valid", cmd_valid, 1'b1);
    check("bp_addr", cmd_addr, 32'h160);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_addr", cmd_addr, 32'h160);
      check("bp_hold_pop", src_pop, 1'b0);
    end
    cmd_ready = 1;
    #1;
    check("bp_pop_on_accept", src_pop, 1'b1);
    step();

    // Disable while a data command is pending.
    dma_en = 0;
    repeat (3) step();
    dma_en = 1; cmd_ready = 0;
    n = 0;
    while (n < 5 && !cmd_valid) begin step(); n++; end
    check("dis_pending_valid", cmd_valid, 1'b1);
    check("dis_pending_addr", cmd_addr, 32'h100);
    dma_en = 0;
    repeat (3) step();
    check("dis_not_withdrawn", cmd_valid, 1'b1);
    n0 = accq.size(); p0 = pops;
    cmd_ready = 1;
    repeat (4) step();
    check("dis_one_cmd", accq.size() - n0, 1);
    check("dis_one_pop", pops - p0, 1);
    if (accq.size() > 0) check("dis_no_mtr", accq[accq.size()-1].mtr, 1'b0);
    check("dis_wr_ptr", wr_ptr, '0);
    check("dis_busy", busy, 1'b0);
    dma_en = 1;
    n = 0;
    while (n < 6 && accq.size() <= n0 + 1) begin step(); n++; end
    check("reenable_cmd", accq.size(), n0 + 2);
    if (accq.size() > 0) check("reenable_addr", accq[accq.size()-1].addr, 32'h100);

    // Randomized traffic, new bases chosen while disabled.
    dma_en = 0;
    repeat (2) step();
    f2c_base = $urandom; mtr_base = $urandom; rd_ptr = NCL'($urandom);
    n0 = accq.size();
    for (int i = 0; i < 3000; i++) begin
      dma_en    = ($urandom_range(0, 199) != 0);
      src_ready = ($urandom_range(0, 3) != 0);
      cmd_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) rd_ptr = NCL'($urandom);
      step();
    end
    check("random_progress", (accq.size() - n0) > 100, 1'b1);

    // Reset while a metrics write is stalled.
    dma_en = 0;
    repeat (2) step();
    f2c_base = 32'h100; mtr_base = 32'h800; rd_ptr = 0;
    dma_en = 1; src_ready = 1; cmd_ready = 1;
    n = 0;
    while (n < 40 && !m_expect_mtr) begin step(); n++; end
    cmd_ready = 0;
    n = 0;
    while (n < 5 && !cmd_valid) begin step(); n++; end
    check("mtr_pending_valid", cmd_valid, 1'b1);
    check("mtr_pending_kind", cmd_is_mtr, 1'b1);
    rst = 1;
    step();
    check_reset_outputs("mid_mtr_reset");
    rst = 0; dma_en = 0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/f2c_dma_sched.md
F2C_DMA_SCHED -- requirements
Module: f2c_dma_sched

Interface
REQ-001 The block SHALL have parameter NUM_CHUNKS_LOG2, default 2, giving log2 of the number of chunks in the host FPGA->CPU ring.
REQ-002 The block SHALL have parameter CHUNK_TLPS_LOG2, default 2, giving log2 of the number of TLPs per chunk.
REQ-003 The block SHALL have parameter TLP_QWS, default 16, giving QWs per data TLP (power of two).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- pcieClk_in  in  1  sole clock; all state on its rising edge.
- pcieRst_in  in  1  synchronous reset, active high.
- dmaEnable_in  in  1  host DMA_ENABLE register.
- f2cBase_in  in  32  ring base address, QW units.
- mtrBase_in  in  32  metrics buffer base, QW units; the write pointer lands here.
- rdPtr_in  in  NUM_CHUNKS_LOG2  host F2C_RDPTR register.
- srcTlpReady_in  in  1  source holds at least one full TLP of data.
- srcTlpPop_out  out  1  one-cycle pulse: the source's head TLP has been consumed.
- cmdValid_out  out  1  command valid to the TLP transmitter.
- cmdReady_in  in  1  transmitter accepts the command this cycle.
- cmdIsMtr_out  out  1  0 = data TLP (TLP_QWS QWs from source); 1 = single-DW metrics write.
- cmdAddr_out  out  32  command target address, QW units.
- cmdData_out  out  32  metrics payload (zero-extended wrPtr); 0 for data commands.
- wrPtr_out  out  NUM_CHUNKS_LOG2  current ring write pointer.
- busy_out  out  1  state is not IDLE.
- stallCount_out  out  32  full-ring stall cycles (see Configuration).

Function
REQ-005 The block SHALL implement states IDLE, DATA and MTR, and SHALL keep internal counter tlpIdx of CHUNK_TLPS_LOG2 bits.
REQ-006 In IDLE with dmaEnable_in=0, the block SHALL clear wrPtr and tlpIdx to 0 every cycle.
REQ-007 The block SHALL go IDLE->DATA when all of these hold: dmaEnable_in=1, srcTlpReady_in=1, and either tlpIdx!=0 or ((wrPtr+1) mod 2^NUM_CHUNKS_LOG2) != rdPtr_in.
REQ-008 The ring-full test SHALL be evaluated only at a chunk start (tlpIdx=0); a chunk in progress SHALL complete without re-checking rdPtr_in.
REQ-009 In DATA the block SHALL drive these outputs, registered, from the cycle after entry: cmdValid_out=1, cmdIsMtr_out=0, cmdAddr_out=f2cBase_in+((wrPtr<<CHUNK_TLPS_LOG2)+tlpIdx)*TLP_QWS (32-bit wrap), cmdData_out=0.
REQ-010 All cmd* outputs SHALL stay stable while cmdValid_out=1 and cmdReady_in=0; a valid command SHALL never be withdrawn, including when dmaEnable_in falls.
REQ-011 On DATA accept (cmdValid_out and cmdReady_in), the block SHALL pulse srcTlpPop_out for exactly that cycle and SHALL increment tlpIdx, wrapping.
- If tlpIdx was not all-ones: go to IDLE.
- If tlpIdx was all-ones: increment wrPtr (wrapping) and go to MTR.
REQ-012 In MTR the block SHALL drive cmdValid_out=1, cmdIsMtr_out=1, cmdAddr_out=mtrBase_in, cmdData_out={0,wrPtr} (the new value); on accept it SHALL go to IDLE.
REQ-013 Minimum spacing SHALL be one IDLE cycle between commands; with cmdReady_in tied 1, one chunk SHALL take exactly 2*2^CHUNK_TLPS_LOG2+2 cycles (4 TLPs -> 10).
REQ-014 cmdValid_out SHALL be 0 in IDLE; srcTlpPop_out SHALL never pulse outside a DATA accept.
REQ-015 If dmaEnable_in falls mid-chunk, the pending command SHALL complete, and the following IDLE cycle SHALL clear wrPtr and tlpIdx; no metrics write SHALL be issued for a partial chunk.
REQ-016 busy_out SHALL be 1 in DATA and MTR, 0 in IDLE; wrPtr_out SHALL equal internal wrPtr.

Reset
REQ-017 While pcieRst_in=1, the block SHALL enter IDLE and set wrPtr=0, tlpIdx=0, cmdValid_out=0, cmdIsMtr_out=0, cmdAddr_out=0, cmdData_out=0, srcTlpPop_out=0, busy_out=0 and stallCount_out=0.
REQ-018 Reset mid-command SHALL drop cmdValid_out on the next edge, taking priority over handshakes.

Configuration
REQ-019 Macro F2C_STALL_COUNT_EN SHALL compile the stall counter in or out.
- Defined: stallCount_out SHALL increment, saturating at 0xFFFFFFFF, on each IDLE cycle with dmaEnable_in=1, srcTlpReady_in=1, tlpIdx=0 and the ring full; it SHALL clear while dmaEnable_in=0.
- Undefined: stallCount_out SHALL be constant 0, with no counter logic.

Verification
REQ-020 Reset, f2cBase=0x100, mtrBase=0x800, rdPtr=0, enable, srcTlpReady=1, cmdReady=1 -> data addrs 0x100,0x110,0x120,0x130, then MTR addr 0x800 data 1; 4 pops; 10 cycles per chunk.
REQ-021 As REQ-020, rdPtr held 0 -> chunks 0,1,2 written (MTR data 1,2,3); the block then idles with wrPtr_out=3; setting rdPtr=1 -> next data addr 0x1C0, MTR data 0.
REQ-022 Mid-chunk 1, tlpIdx=2 -> addr 0x160; cmdReady held 0 for 5 cycles -> cmd* stable, no pop until accept.
REQ-023 Drop dmaEnable while a DATA command is pending -> command completes with 1 pop, then wrPtr_out=0, no MTR; re-enable restarts at addr 0x100.
REQ-024 With F2C_STALL_COUNT_EN, ring full for 20 IDLE cycles -> stallCount_out=20, then 0 after disable; without the macro -> always 0.
REQ-025 Assert pcieRst_in during MTR with cmdReady=0 -> next cycle cmdValid_out=0, all outputs at their reset values.
